// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, lane states and FIFO entry type for the convolution output packer.
package conv_pkg;
  localparam int PIX_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES = WORD_W / PIX_W;
  typedef logic [WORD_W-1:0] word_t;
  typedef struct packed {
    logic last;
    word_t word;
  } fifo_ent_t;
  typedef enum logic [1:0] {LANE0, LANE1, LANE2, LANE3} lane_e;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO of fifo_ent_t, wrap-bit pointers, head reads zero when empty.
module sync_fifo_fwft
  import conv_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  fifo_ent_t                din,
  output fifo_ent_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  fifo_ent_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign level = wp - rp;
  assign empty = wp == rp;
  assign full = level == (AW+1)'(DEPTH);
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !clr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/conv_out_packer.sv
// conv_out_packer: packs 8-bit pixels into 32-bit LE words with frame-last marking into a FWFT FIFO.
// PACKER_STATS_EN adds a saturating dropped-word counter port.
module conv_out_packer #(
  parameter int PIX_W = 8,
  parameter int WORD_W = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_PIX = 611204
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clr,
  input  logic                          valid_in,
  input  logic [PIX_W-1:0]              px_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WORD_W-1:0]             m_data,
  output logic                          m_last,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PACKER_STATS_EN
  ,output logic [15:0]                  dropped_cnt
`endif
);
  import conv_pkg::*;
  localparam int CW = $clog2(FRAME_PIX);
  lane_e lane;
  word_t acc, nxt;
  logic [CW-1:0] cnt;
  logic is_last, push_req, push, pop, drop, full, empty;
  fifo_ent_t head;
  assign is_last = cnt == CW'(FRAME_PIX - 1);
  assign push_req = valid_in && !clr && (lane == lane_e'(LANES - 1) || is_last);
  assign pop = m_valid && m_ready;
  // a full FIFO still accepts when the head leaves on the same edge
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;
  assign m_valid = !empty;
  assign m_data = head.word;
  assign m_last = head.last;
  always_comb begin
    nxt = acc;
    nxt[int'(lane)*PIX_W +: PIX_W] = px_in;
  end
  sync_fifo_fwft #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .clr(clr),
    .push(push),
    .pop(pop),
    .din('{last: is_last, word: nxt}),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      lane <= LANE0;
      acc <= '0;
      cnt <= '0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      lane <= LANE0;
      acc <= '0;
      cnt <= '0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      frame_done <= valid_in && is_last;
      if (drop) overflow <= 1'b1;
      if (valid_in) begin
        lane <= is_last ? LANE0 : lane_e'(lane + 2'd1);
        acc <= (lane == lane_e'(LANES - 1) || is_last) ? '0 : nxt;
        cnt <= is_last ? '0 : cnt + 1'b1;
      end
    end
`ifdef PACKER_STATS_EN
  always_ff @(posedge clk or posedge rstn)
    if (rstn) dropped_cnt <= '0;
    else if (clr) dropped_cnt <= '0;
    else if (drop && dropped_cnt != 16'hFFFF) dropped_cnt <= dropped_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_conv_out_packer.sv
// tb_conv_out_packer: scoreboard bench for conv_out_packer with a 4-deep FIFO and 6-pixel frames.
module tb_conv_out_packer;
  localparam int DEPTH = 4;
  localparam int FP = 6;
  logic clk = 0, rstn = 1, clr = 0, valid_in = 0, m_ready = 0;
  logic [7:0] px_in = 0;
  logic m_valid, m_last, frame_done, overflow;
  logic [31:0] m_data;
  logic [2:0] fifo_level;
`ifdef PACKER_STATS_EN
  logic [15:0] dropped_cnt;
`endif
  int vectors = 0, errors = 0;
  typedef struct {
    bit last;
    bit [31:0] word;
  } ent_t;
  ent_t q[$], got[$];
  int lane = 0, cnt = 0, lvl = 0, drops = 0;
  bit [31:0] acc = 0;
  bit ovf = 0, fd = 0, pop_m, last_m;

  conv_out_packer #(.PIX_W(8), .WORD_W(32), .FIFO_DEPTH(DEPTH), .FRAME_PIX(FP)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .valid_in(valid_in), .px_in(px_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_done(frame_done), .overflow(overflow), .fifo_level(fifo_level)
`ifdef PACKER_STATS_EN
    , .dropped_cnt(dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  // reference packer and FIFO occupancy, advanced on the same edge as the DUT
  always @(posedge clk) begin
    if (rstn || clr) begin
      lane = 0; cnt = 0; acc = 0; lvl = 0; ovf = 0; fd = 0; drops = 0;
      q.delete();
    end else begin
      pop_m = m_ready && lvl > 0;
      fd = 0;
      if (valid_in) begin
        acc[lane*8 +: 8] = px_in;
        last_m = cnt == FP - 1;
        if (lane == 3 || last_m) begin
          if (lvl < DEPTH || pop_m) begin
            q.push_back('{last_m, acc});
            lvl++;
          end else begin
            ovf = 1;
            if (drops < 16'hFFFF) drops++;
          end
          acc = 0;
          lane = 0;
        end else lane++;
        fd = last_m;
        cnt = last_m ? 0 : cnt + 1;
      end
      if (pop_m) lvl--;
    end
  end

  always @(negedge clk)
    if (!rstn) begin
      vectors++;
      if (m_valid !== (lvl > 0)) begin errors++; $display("FAIL m_valid got %b exp %b", m_valid, lvl > 0); end
      vectors++;
      if (fifo_level !== 3'(lvl)) begin errors++; $display("FAIL fifo_level got %0d exp %0d", fifo_level, lvl); end
      vectors++;
      if (overflow !== ovf) begin errors++; $display("FAIL overflow got %b exp %b", overflow, ovf); end
      vectors++;
      if (frame_done !== fd) begin errors++; $display("FAIL frame_done got %b exp %b", frame_done, fd); end
`ifdef PACKER_STATS_EN
      vectors++;
      if (dropped_cnt !== 16'(drops)) begin errors++; $display("FAIL dropped_cnt got %0d exp %0d", dropped_cnt, drops); end
`endif
      if (lvl > 0 && q.size() > 0) begin
        vectors++;
        if ({m_last, m_data} !== {q[0].last, q[0].word}) begin
          errors++;
          $display("FAIL head got %b/%h exp %b/%h", m_last, m_data, q[0].last, q[0].word);
        end
        if (m_ready) begin
          got.push_back('{m_last, m_data});
          void'(q.pop_front());
        end
      end
    end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic pix(input logic [7:0] p); valid_in = 1; px_in = p; tick; valid_in = 0; endtask
  task automatic do_clr; clr = 1; tick; clr = 0; endtask
  task automatic drain;
    m_ready = 1;
    for (int i = 0; i < 60 && m_valid; i++) tick;
    vectors++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL drain timeout m_valid=%b level=%0d", m_valid, fifo_level); end
    m_ready = 0;
  endtask

  task automatic test_reset;
    rstn = 1;
    repeat (3) tick;
    vectors++;
    if ({m_valid, m_data, m_last, frame_done, overflow, fifo_level} !== '0) begin
      errors++;
      $display("FAIL reset got v=%b d=%h l=%b fd=%b ov=%b lvl=%0d exp all 0", m_valid, m_data, m_last, frame_done, overflow, fifo_level);
    end
    rstn = 0;
    tick;
  endtask

  task automatic test_basic;
    do_clr; got.delete();
    m_ready = 1;
    for (int i = 1; i <= 6; i++) pix(8'(i));
    drain;
    vectors++;
    if (got.size() != 2 || got[0].word !== 32'h04030201 || got[0].last !== 1'b0 ||
        got[1].word !== 32'h00000605 || got[1].last !== 1'b1) begin
      errors++;
      $display("FAIL basic got n=%0d %h/%b %h/%b exp 04030201/0 00000605/1", got.size(), got[0].word, got[0].last, got[1].word, got[1].last);
    end
  endtask

  task automatic test_partial;
    got.delete();
    m_ready = 1;
    for (int i = 0; i < 6; i++) pix(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) pix(8'h11 + 8'(i));
    drain;
    vectors++;
    if (got.size() != 3 || got[0].word !== 32'hA3A2A1A0 || got[1].word !== 32'h0000A5A4 ||
        got[1].last !== 1'b1 || got[2].word !== 32'h14131211 || got[2].last !== 1'b0) begin
      errors++;
      $display("FAIL partial got n=%0d %h %h/%b %h/%b exp A3A2A1A0 0000A5A4/1 14131211/0", got.size(), got[0].word, got[1].word, got[1].last, got[2].word, got[2].last);
    end
  endtask

  task automatic test_overflow;
    bit [31:0] exp_w [4] = '{32'h04030201, 32'h00000605, 32'h0A090807, 32'h00000C0B};
    do_clr; got.delete();
    m_ready = 0;
    for (int i = 0; i < 20; i++) begin
      pix(8'(i + 1));
      if (i == 14) begin
        vectors++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
      end
      if (i == 15) begin
        vectors++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_5th got %b exp 1", overflow); end
`ifdef PACKER_STATS_EN
        vectors++;
        if (dropped_cnt !== 16'd1) begin errors++; $display("FAIL dropped_5th got %0d exp 1", dropped_cnt); end
`endif
      end
    end
    vectors++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_full got lvl=%0d ov=%b exp 4/1", fifo_level, overflow);
    end
`ifdef PACKER_STATS_EN
    vectors++;
    if (dropped_cnt !== 16'd2) begin errors++; $display("FAIL dropped_end got %0d exp 2", dropped_cnt); end
`endif
    drain;
    vectors++;
    if (got.size() != 4) begin errors++; $display("FAIL ovf_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vectors++;
      if (got[i].word !== exp_w[i] || got[i].last !== 1'(i % 2)) begin
        errors++; $display("FAIL ovf_word%0d got %h/%b exp %h/%b", i, got[i].word, got[i].last, exp_w[i], i % 2);
      end
    end
  endtask

  task automatic test_clear;
    do_clr;
    vectors++;
    if (fifo_level !== 3'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL clr_state got lvl=%0d ov=%b exp 0/0", fifo_level, overflow);
    end
    pix(8'hE1); pix(8'hE2);
    do_clr;
    clr = 1; valid_in = 1; px_in = 8'hEE; tick; clr = 0; valid_in = 0;
    vectors++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL clr_level got %0d exp 0", fifo_level); end
    got.delete();
    m_ready = 1;
    for (int i = 0; i < 4; i++) pix(8'h11 + 8'(i));
    drain;
    vectors++;
    if (got.size() != 1 || got[0].word !== 32'h14131211 || got[0].last !== 1'b0) begin
      errors++; $display("FAIL clr_word got n=%0d %h/%b exp 14131211/0", got.size(), got[0].word, got[0].last);
    end
  endtask

  task automatic test_full_pop;
    do_clr; got.delete();
    m_ready = 0;
    for (int i = 1; i <= 15; i++) pix(8'(i));
    vectors++;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpop_pre got %0d exp 4", fifo_level); end
    m_ready = 1;
    pix(8'h10);
    m_ready = 0;
    vectors++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL fullpop got lvl=%0d ov=%b exp 4/0", fifo_level, overflow);
    end
    drain;
    vectors++;
    if (got.size() != 5 || got[4].word !== 32'h100F0E0D) begin
      errors++; $display("FAIL fullpop_tail got n=%0d %h exp 5 100F0E0D", got.size(), got[4].word);
    end
  endtask

  task automatic test_backpressure;
    do_clr; got.delete();
    for (int i = 0; i < 3 * FP; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) tick;
      m_ready = 1'($urandom_range(0, 1));
      pix(8'($urandom));
    end
    drain;
    vectors++;
    if (got.size() + drops != 6) begin
      errors++; $display("FAIL bp_words got %0d popped + %0d dropped exp 6", got.size(), drops);
    end
  endtask

  task automatic test_rst_mid;
    m_ready = 0;
    pix(8'h31); pix(8'h32); pix(8'h33);
    rstn = 1; tick; tick; rstn = 0; got.delete();
    m_ready = 1;
    for (int i = 0; i < 4; i++) pix(8'h21 + 8'(i));
    drain;
    vectors++;
    if (got.size() != 1 || got[0].word !== 32'h24232221) begin
      errors++; $display("FAIL rst_mid got n=%0d %h exp 24232221", got.size(), got[0].word);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_partial;
    test_overflow;
    test_clear;
    test_full_pop;
    test_backpressure;
    test_rst_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_out_packer.md
# conv_out_packer

Downstream stage of the streaming 3x3 convolution core. Collects the core's 8-bit output pixel stream (valid-only, no backpressure) into 32-bit little-endian words and buffers them in a first-word-fall-through FIFO. The words are presented on a ready/valid master port toward the LiteX DMA/CSR side. The block marks the last word of each frame, pads a partial final word, and flags any overflow caused by the upstream's inability to stall.

## Interface
- PIX_W, 8, pixel width; must equal WORD_W/4
- WORD_W, 32, output word width
- FIFO_DEPTH, 16, word entries; power of two, >= 4
- FRAME_PIX, 611204, output pixels per frame ((640-2)*(960-2))
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear: drops partial word, empties FIFO, zeroes pixel counter, clears overflow
- valid_in  in  1  pixel strobe from the convolution core
- px_in  in  PIX_W  pixel value
- m_valid  out  1  FIFO head word available
- m_ready  in  1  consumer accepts the head word
- m_data  out  WORD_W  head word; pixel k of the word is in bits [8k+7:8k]
- m_last  out  1  head word is the final word of a frame
- frame_done  out  1  one-cycle pulse when the final pixel of a frame is packed
- overflow  out  1  sticky; a word was dropped because the FIFO was full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current word count

## Operation
- Packer FSM states:
  - LANE0..LANE3: lane index of the next pixel.
  - A valid_in beat writes px_in into the current lane and advances the state; LANE3 wraps to LANE0.
- A word is pushed when either:
  - the LANE3 pixel is written, or
  - the pixel is the FRAME_PIX-th of the frame, in any lane. Unfilled higher lanes are zero. m_last=1 is stored with this word, frame_done pulses, the pixel counter wraps to 0, and the FSM returns to LANE0.
- Pixel counter: 0..FRAME_PIX-1. It advances on every valid_in, including beats whose word is later dropped.
- Push rule: the push succeeds if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the word is discarded and overflow is set. The frame/lane sequence continues unaffected.
- Pop: occurs on m_valid && m_ready.
  - m_data and m_last stay stable while m_valid && !m_ready.
  - m_ready is ignored while m_valid=0.
- clr takes priority over valid_in in the same cycle. The pixel on that cycle is discarded.
- rstn mid-frame: all state is lost, with the same result as clr.
- Reset values:
  - m_valid=0, m_data=0, m_last=0, frame_done=0, overflow=0, fifo_level=0
  - FSM in LANE0, pixel counter 0

## Timing
- The completing pixel is sampled at edge N. The word enters the FIFO at edge N. m_valid is high after edge N when the FIFO was empty, giving 1-cycle latency from the sampled edge.
- frame_done is high for the cycle following edge N of the last pixel.
- Sustained throughput: one pixel per clock in, one word per 4 clocks out. A consumer holding m_ready=1 never causes overflow.
- fifo_level updates on the same edge as the push or pop. A simultaneous push and pop leaves fifo_level unchanged.

## Configuration
- PACKER_STATS_EN defined:
  - Adds output port dropped_cnt[15:0]: the count of discarded words, saturating at 0xFFFF.
  - Cleared by clr and by rstn.
- PACKER_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- conv_pkg holds:
  - the PIX_W and WORD_W constants
  - LANES = WORD_W/PIX_W
  - typedef word_t (WORD_W bits)
  - typedef fifo_ent_t: packed struct of last plus word_t
- Sub-module sync_fifo_fwft:
  - generic width/depth, power-of-two pointers with an extra wrap bit
  - push/pop/full/empty/level
  - stores fifo_ent_t

## Test plan
- **Basic packing:** FRAME_PIX=8, pixels 0x01..0x08 back-to-back, m_ready=1. Expect words 0x04030201 (m_last=0), then 0x08070605 (m_last=1), and one frame_done pulse.
- **Partial final word:** FRAME_PIX=6, pixels 0xA0..0xA5. Expect second word 0x0000A5A4 with m_last=1, and the next frame starting at lane 0.
- **Overflow:** FIFO_DEPTH=4, m_ready=0, 20 pixels. Expect fifo_level=4, overflow=1 after the 5th word, and dropped_cnt=1 with PACKER_STATS_EN. Release m_ready: expect exactly the first 4 words in order.
- **Backpressure stability:** toggle m_ready randomly over 3 frames of FRAME_PIX=12. Expect m_data unchanged while stalled, and the output stream to equal the reference packing.
- **Clear mid-word:** 2 pixels, then clr. Expect the next 4 pixels 0x11..0x14 to give word 0x14131211, fifo_level=0 immediately after clr, and overflow=0.
- **Full with simultaneous pop:** FIFO full and m_ready=1 on the push cycle. Expect the push accepted, fifo_level held at 4, and overflow=0.
